// File: rtl/xmult_arbiter.sv
// xmult_arbiter: round-robin arbiter and sequencer that shares one 16x16
// unsigned multiplier peripheral between two requesters. A granted request
// walks LOAD_A -> LOAD_B -> READ -> DONE. The product is captured into that
// requester's result register, and done pulses for one cycle.
module xmult_arbiter #(
  parameter int OP_W  = 16,
  parameter int RES_W = 2 * OP_W
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             req0,
  input  logic             req1,
  input  logic [OP_W-1:0]  a0,
  input  logic [OP_W-1:0]  b0,
  input  logic [OP_W-1:0]  a1,
  input  logic [OP_W-1:0]  b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [RES_W-1:0] res0,
  output logic [RES_W-1:0] res1,
  output logic             busy,
  output logic             mult_sel,
  output logic [OP_W-1:0]  mult_number,
  output logic [1:0]       mult_addr,
  input  logic [RES_W-1:0] mult_data
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  // The last-served pointer also identifies the owner of the operation in
  // flight. It updates to the winner on grant and holds until the next grant.
  logic             ptr_reg;
  logic [OP_W-1:0]  a_reg;
  logic [OP_W-1:0]  b_reg;
  logic [RES_W-1:0] res0_reg;
  logic [RES_W-1:0] res1_reg;
  logic             any_req;
  logic             winner;

  assign any_req = req0 | req1;
  // On a tie the requester that was not served last wins. With one request,
  // that requester wins: when req1 is low, the winner is requester 0.
  assign winner  = (req0 & req1) ? ~ptr_reg : req1;

  // Next-state sequencing. Requests are only evaluated in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_LOAD_A;
      ST_LOAD_A: state_next = ST_LOAD_B;
      ST_LOAD_B: state_next = ST_READ;
      ST_READ:   state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, pointer and operand latch. The operands are frozen at grant, so
  // later changes to a/b do not affect the operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 1'b1;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && any_req) begin
        ptr_reg <= winner;
        a_reg   <= winner ? a1 : a0;
        b_reg   <= winner ? b1 : b0;
      end
    end
  end

  // Result capture at the end of READ, into the owner's register only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res0_reg <= '0;
      res1_reg <= '0;
    end else if (state_reg == ST_READ) begin
      if (ptr_reg) res1_reg <= mult_data;
      else         res0_reg <= mult_data;
    end
  end

  // Multiplier port drive. This is decoded from state, so a reset clears it
  // immediately.
  always_comb begin
    mult_sel    = 1'b0;
    mult_addr   = 2'd0;
    mult_number = '0;
    case (state_reg)
      ST_LOAD_A: begin
        mult_sel    = 1'b1;
        mult_addr   = 2'd0;
        mult_number = a_reg;
      end
      ST_LOAD_B: begin
        mult_sel    = 1'b1;
        mult_addr   = 2'd1;
        mult_number = b_reg;
      end
      ST_READ: begin
        mult_addr   = 2'd2;
      end
      default: begin
        mult_sel    = 1'b0;
      end
    endcase
  end

  assign busy  = (state_reg != ST_IDLE);
  assign gnt0  = busy & ~ptr_reg;
  assign gnt1  = busy &  ptr_reg;
  assign done0 = (state_reg == ST_DONE) & ~ptr_reg;
  assign done1 = (state_reg == ST_DONE) &  ptr_reg;
  assign res0  = res0_reg;
  assign res1  = res1_reg;

endmodule

// File: tb/tb_xmult_arbiter.sv
// tb_xmult_arbiter: directed bench for xmult_arbiter. It contains a
// behavioural model of the multiplier peripheral. Each scenario task drives
// its own stimulus and checks the results against hand-computed values.
module tb_xmult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, busy, mult_sel;
  logic [31:0] res0, res1, mult_data;
  logic [15:0] mult_number;
  logic [1:0]  mult_addr;

  int vectors = 0;
  int miscompares = 0;

  // Control view: {gnt0,gnt1,busy,done0,done1,mult_sel,mult_addr,mult_number}
  logic [23:0] ctl;
  assign ctl = {gnt0, gnt1, busy, done0, done1, mult_sel, mult_addr, mult_number};

  always #5 clk = ~clk;

  xmult_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1), .busy(busy),
    .mult_sel(mult_sel), .mult_number(mult_number), .mult_addr(mult_addr),
    .mult_data(mult_data)
  );

  // Multiplier peripheral model: two operand registers and a combinational
  // product on address 2.
  logic [15:0] m_op1 = '0;
  logic [15:0] m_op2 = '0;
  always @(posedge clk) begin
    if (mult_sel && mult_addr == 2'd0) m_op1 <= mult_number;
    if (mult_sel && mult_addr == 2'd1) m_op2 <= mult_number;
  end
  assign mult_data = (mult_addr == 2'd2) ? 32'(m_op1) * 32'(m_op2) : 32'd0;

  task automatic test_reset();
    rst = 1'b0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (3) @(negedge clk);
    vectors++; if (ctl !== 24'd0) begin miscompares++; $display("FAIL reset_ctl: got %h want %h", ctl, 24'd0); end
    vectors++; if (res0 !== 32'd0) begin miscompares++; $display("FAIL reset_res0: got %h want %h", res0, 32'd0); end
    vectors++; if (res1 !== 32'd0) begin miscompares++; $display("FAIL reset_res1: got %h want %h", res1, 32'd0); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    req0 = 1; a0 = 16'd3; b0 = 16'd5;
    @(negedge clk); // cycle 1
    vectors++; if (ctl !== {6'b101001, 2'd0, 16'd3}) begin miscompares++; $display("FAIL single_c1: got %h want %h", ctl, {6'b101001, 2'd0, 16'd3}); end
    @(negedge clk); // cycle 2
    vectors++; if (ctl !== {6'b101001, 2'd1, 16'd5}) begin miscompares++; $display("FAIL single_c2: got %h want %h", ctl, {6'b101001, 2'd1, 16'd5}); end
    vectors++; if (m_op1 !== 16'd3) begin miscompares++; $display("FAIL single_op1_written: got %h want %h", m_op1, 16'd3); end
    @(negedge clk); // cycle 3
    vectors++; if (ctl !== {6'b101000, 2'd2, 16'd0}) begin miscompares++; $display("FAIL single_c3: got %h want %h", ctl, {6'b101000, 2'd2, 16'd0}); end
    @(negedge clk); // cycle 4
    vectors++; if (ctl[23:19] !== 5'b10110) begin miscompares++; $display("FAIL single_c4_done: got %b want %b", ctl[23:19], 5'b10110); end
    vectors++; if (res0 !== 32'd15) begin miscompares++; $display("FAIL single_res0: got %0d want 15", res0); end
    req0 = 0;
    @(negedge clk); // cycle 5
    vectors++; if (ctl !== 24'd0) begin miscompares++; $display("FAIL single_c5_idle: got %h want %h", ctl, 24'd0); end
    vectors++; if (res1 !== 32'd0) begin miscompares++; $display("FAIL single_res1_untouched: got %h want 0", res1); end
  endtask

  task automatic test_max();
    req1 = 1; a1 = 16'hFFFF; b1 = 16'hFFFF;
    repeat (4) @(negedge clk);
    vectors++; if (ctl[23:19] !== 5'b01101) begin miscompares++; $display("FAIL max_c4_done: got %b want %b", ctl[23:19], 5'b01101); end
    vectors++; if (res1 !== 32'hFFFE0001) begin miscompares++; $display("FAIL max_res1: got %h want %h", res1, 32'hFFFE0001); end
    req1 = 0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL max_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_retention();
    req1 = 1; a1 = 16'd2; b1 = 16'd3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL retain_done0_c%0d: got %b want 0", k, done0); end
    end
    vectors++; if (res0 !== 32'd15) begin miscompares++; $display("FAIL retain_res0: got %0d want 15", res0); end
    vectors++; if (res1 !== 32'd6) begin miscompares++; $display("FAIL retain_res1: got %0d want 6", res1); end
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    req0 = 1; a0 = 16'd6; b0 = 16'd6;
    @(negedge clk); // cycle 1
    vectors++; if (mult_number !== 16'd6) begin miscompares++; $display("FAIL opchg_c1_number: got %0d want 6", mult_number); end
    a0 = 16'd100; req0 = 0;
    @(negedge clk); // cycle 2
    vectors++; if (mult_number !== 16'd6) begin miscompares++; $display("FAIL opchg_c2_number: got %0d want 6", mult_number); end
    repeat (2) @(negedge clk); // cycle 4
    vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL opchg_done0: got %b want 1", done0); end
    vectors++; if (res0 !== 32'd36) begin miscompares++; $display("FAIL opchg_res0: got %0d want 36", res0); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req0 = 1; a0 = 16'd9; b0 = 16'd9;
    repeat (2) @(negedge clk); // cycle 2, LOAD_B
    req0 = 0;
    #2 rst = 1'b0;
    #1;
    vectors++; if (ctl !== 24'd0) begin miscompares++; $display("FAIL arst_ctl_immediate: got %h want %h", ctl, 24'd0); end
    vectors++; if (res1 !== 32'd0) begin miscompares++; $display("FAIL arst_res1_cleared: got %h want 0", res1); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL arst_no_done_%0d: got %b want 0", k, done0); end
    end
    rst = 1'b1;
    req0 = 1; a0 = 16'd7; b0 = 16'd8;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++; if (done0 !== (k == 4)) begin miscompares++; $display("FAIL arst_done0_c%0d: got %b want %b", k, done0, (k == 4)); end
    end
    vectors++; if (res0 !== 32'd56) begin miscompares++; $display("FAIL arst_res0: got %0d want 56", res0); end
    req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1; req1 = 1; a0 = 16'd2; b0 = 16'd7; a1 = 16'd4; b1 = 16'd9;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      // {gnt0, gnt1, done0, done1}
      exp = {(k <= 4 || k == 11), (k >= 6 && k <= 9), (k == 4), (k == 9)};
      vectors++; if ({gnt0, gnt1, done0, done1} !== exp) begin miscompares++; $display("FAIL b2b_c%0d: got %b want %b", k, {gnt0, gnt1, done0, done1}, exp); end
      if (k == 4) begin
        vectors++; if (res0 !== 32'd14) begin miscompares++; $display("FAIL b2b_res0: got %0d want 14", res0); end
      end
      if (k == 9) begin
        vectors++; if (res1 !== 32'd36) begin miscompares++; $display("FAIL b2b_res1: got %0d want 36", res1); end
      end
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk); // cycle 14
    vectors++; if ({done0, done1} !== 2'b10) begin miscompares++; $display("FAIL b2b_third_done: got %b want 10", {done0, done1}); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_final_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_retention();
    test_operand_change();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
